input_conditioner: RTL and testbench

INPUT_CONDITIONER -- requirements
Module: input_conditioner

---
 rtl/input_conditioner.sv | 165 ++++++++++++++++
 tb/tb_input_conditioner.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// Conditions the raw board inputs for the multiplier: two-flop synchronizers,
// a debounce FSM per push button, press strobes and a run-frozen switch operand.
module input_conditioner #(
    parameter int DB_CYCLES = 16,
    parameter int SW_WIDTH  = 8
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Run_raw,
    input  logic                ClearA_LoadB_raw,
    input  logic [SW_WIDTH-1:0] SW_raw,
    output logic                Run,
    output logic                ClearA_LoadB,
    output logic [SW_WIDTH-1:0] S,
    output logic                Run_pulse,
    output logic                Clear_pulse
);

    localparam int NB = 2;
    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    // Last count value before acceptance; the accepting edge would make it DB_CYCLES.
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        REL   = 2'd0,
        CHK_P = 2'd1,
        PRS   = 2'd2,
        CHK_R = 2'd3
    } db_state_t;

    // Button index 0 is Run, index 1 is ClearA_LoadB.
    logic [NB-1:0]       btn_raw_s;
    logic [NB-1:0]       btn_meta_r;
    logic [NB-1:0]       btn_sync_r;
    logic [SW_WIDTH-1:0] sw_meta_r;
    logic [SW_WIDTH-1:0] sw_sync_r;
    logic [SW_WIDTH-1:0] s_r;

    db_state_t           state_r [NB];
    db_state_t           state_s [NB];
    logic [CW-1:0]       count_r [NB];
    logic [CW-1:0]       count_s [NB];
    logic [NB-1:0]       level_r;
    logic [NB-1:0]       level_s;
    logic [NB-1:0]       pulse_r;
    logic [NB-1:0]       pulse_s;

    assign btn_raw_s = {ClearA_LoadB_raw, Run_raw};

    // Two-flop synchronizers; idle buttons read high, switches read zero.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            btn_meta_r <= {NB{1'b1}};
            btn_sync_r <= {NB{1'b1}};
            sw_meta_r  <= {SW_WIDTH{1'b0}};
            sw_sync_r  <= {SW_WIDTH{1'b0}};
        end else begin
            btn_meta_r <= btn_raw_s;
            btn_sync_r <= btn_meta_r;
            sw_meta_r  <= SW_raw;
            sw_sync_r  <= sw_meta_r;
        end
    end

    // Debounce next-state logic; a press strobe fires only on the accepting edge of a press.
    always_comb begin
        for (int i = 0; i < NB; i++) begin
            state_s[i] = state_r[i];
            count_s[i] = count_r[i];
            level_s[i] = level_r[i];
            pulse_s[i] = 1'b0;
            case (state_r[i])
                REL: begin
                    if (!btn_sync_r[i]) begin
                        state_s[i] = CHK_P;
                        count_s[i] = CNT_ONE;
                    end else begin
                        count_s[i] = CNT_ZERO;
                    end
                end
                CHK_P: begin
                    if (!btn_sync_r[i]) begin
                        if (count_r[i] == CNT_LAST) begin
                            state_s[i] = PRS;
                            count_s[i] = CNT_ZERO;
                            level_s[i] = 1'b0;
                            pulse_s[i] = 1'b1;
                        end else begin
                            count_s[i] = count_r[i] + CNT_ONE;
                        end
                    end else begin
                        state_s[i] = REL;
                        count_s[i] = CNT_ZERO;
                    end
                end
                PRS: begin
                    if (btn_sync_r[i]) begin
                        state_s[i] = CHK_R;
                        count_s[i] = CNT_ONE;
                    end else begin
                        count_s[i] = CNT_ZERO;
                    end
                end
                CHK_R: begin
                    if (btn_sync_r[i]) begin
                        if (count_r[i] == CNT_LAST) begin
                            state_s[i] = REL;
                            count_s[i] = CNT_ZERO;
                            level_s[i] = 1'b1;
                        end else begin
                            count_s[i] = count_r[i] + CNT_ONE;
                        end
                    end else begin
                        state_s[i] = PRS;
                        count_s[i] = CNT_ZERO;
                    end
                end
                default: begin
                    state_s[i] = REL;
                    count_s[i] = CNT_ZERO;
                    level_s[i] = 1'b1;
                end
            endcase
        end
    end

    // Debounce state, counters, levels and strobes.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            for (int i = 0; i < NB; i++) begin
                state_r[i] <= REL;
                count_r[i] <= CNT_ZERO;
            end
            level_r <= {NB{1'b1}};
            pulse_r <= {NB{1'b0}};
        end else begin
            for (int i = 0; i < NB; i++) begin
                state_r[i] <= state_s[i];
                count_r[i] <= count_s[i];
            end
            level_r <= level_s;
            pulse_r <= pulse_s;
        end
    end

    // Operand tracks the switches only while Run is released, using Run as registered before this edge.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            s_r <= {SW_WIDTH{1'b0}};
        end else if (level_r[0]) begin
            s_r <= sw_sync_r;
        end else begin
            s_r <= s_r;
        end
    end

    assign Run          = level_r[0];
    assign ClearA_LoadB = level_r[1];
    assign Run_pulse    = pulse_r[0];
    assign Clear_pulse  = pulse_r[1];
    assign S            = s_r;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner (DB_CYCLES=4): directed timing scenarios plus a
// randomized bouncing-button run, all compared against a streak-count reference model.
module tb_input_conditioner;

    localparam int DB = 4;
    localparam int W  = 8;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         Run_raw;
    logic         ClearA_LoadB_raw;
    logic [W-1:0] SW_raw;
    logic         Run;
    logic         ClearA_LoadB;
    logic [W-1:0] S;
    logic         Run_pulse;
    logic         Clear_pulse;

    input_conditioner #(.DB_CYCLES(DB), .SW_WIDTH(W)) dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .Run_raw          (Run_raw),
        .ClearA_LoadB_raw (ClearA_LoadB_raw),
        .SW_raw           (SW_raw),
        .Run              (Run),
        .ClearA_LoadB     (ClearA_LoadB),
        .S                (S),
        .Run_pulse        (Run_pulse),
        .Clear_pulse      (Clear_pulse)
    );

    always #10 Clk = ~Clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc_idx  = 0;

    // Event bookkeeping from observed outputs, used for latency/pulse-count checks.
    logic prev_run = 1'b1;
    logic prev_clr = 1'b1;
    int   run_fall_cyc, run_rise_cyc, clr_fall_cyc;
    int   run_pulses, clr_pulses, both_pulses;

    // Reference model: 2-edge sampling delay, then a level flips once the sampled
    // value has disagreed with it on DB consecutive edges.
    logic         m_d1 [2];
    logic         m_d2 [2];
    logic         m_level [2];
    logic         m_pulse [2];
    int           m_streak [2];
    logic [W-1:0] m_sw1, m_sw2, m_s;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc_idx);
    endtask

    task automatic model_step(input logic rst, input logic [1:0] btn, input logic [W-1:0] sw);
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                m_d1[i] = 1'b1; m_d2[i] = 1'b1; m_level[i] = 1'b1;
                m_pulse[i] = 1'b0; m_streak[i] = 0;
            end
            m_sw1 = '0; m_sw2 = '0; m_s = '0;
        end else begin
            if (m_level[0]) m_s = m_sw2;
            m_sw2 = m_sw1;
            m_sw1 = sw;
            for (int i = 0; i < 2; i++) begin
                m_pulse[i] = 1'b0;
                if (m_d2[i] != m_level[i]) begin
                    m_streak[i]++;
                    if (m_streak[i] == DB) begin
                        m_level[i]  = ~m_level[i];
                        m_streak[i] = 0;
                        m_pulse[i]  = ~m_level[i];
                    end
                end else begin
                    m_streak[i] = 0;
                end
                m_d2[i] = m_d1[i];
                m_d1[i] = btn[i];
            end
        end
    endtask

    task automatic reset_counters();
        run_fall_cyc = -1; run_rise_cyc = -1; clr_fall_cyc = -1;
        run_pulses = 0; clr_pulses = 0; both_pulses = 0;
    endtask

    task automatic cycle(input logic rst, input logic run_b, input logic clr_b, input logic [W-1:0] sw);
        Reset = rst; Run_raw = run_b; ClearA_LoadB_raw = clr_b; SW_raw = sw;
        @(posedge Clk);
        #1;
        cyc_idx++;
        model_step(rst, {clr_b, run_b}, sw);
        check_eq("Run", 32'(Run), 32'(m_level[0]));
        check_eq("ClearA_LoadB", 32'(ClearA_LoadB), 32'(m_level[1]));
        check_eq("Run_pulse", 32'(Run_pulse), 32'(m_pulse[0]));
        check_eq("Clear_pulse", 32'(Clear_pulse), 32'(m_pulse[1]));
        check_eq("S", 32'(S), 32'(m_s));
        if (prev_run && !Run) run_fall_cyc = cyc_idx;
        if (!prev_run && Run) run_rise_cyc = cyc_idx;
        if (prev_clr && !ClearA_LoadB) clr_fall_cyc = cyc_idx;
        if (Run_pulse) run_pulses++;
        if (Clear_pulse) clr_pulses++;
        if (Run_pulse && Clear_pulse) both_pulses++;
        prev_run = Run;
        prev_clr = ClearA_LoadB;
        @(negedge Clk);
    endtask

    task automatic hold(input logic rst, input logic run_b, input logic clr_b, input logic [W-1:0] sw, input int n);
        for (int i = 0; i < n; i++) cycle(rst, run_b, clr_b, sw);
    endtask

    initial begin
        int seg;
        int run_hold, clr_hold;
        logic rb, cb, rst;
        logic [W-1:0] sw;

        Reset = 1'b0; Run_raw = 1'b1; ClearA_LoadB_raw = 1'b1; SW_raw = 8'h3B;
        reset_counters();
        @(negedge Clk);

        // Reset for two edges, then the operand appears after the third edge.
        hold(1'b0, 1'b1, 1'b1, 8'h3B, 2);
        for (int i = 1; i <= 3; i++) begin
            cycle(1'b1, 1'b1, 1'b1, 8'h3B);
            if (i == 2) check_eq("s_before_load", 32'(S), 32'h0);
            if (i == 3) check_eq("s_after_load", 32'(S), 32'h3B);
        end

        // Clean press and release of Run.
        reset_counters();
        seg = cyc_idx + 1;
        hold(1'b1, 1'b0, 1'b1, 8'h10, 10);
        check_eq("run_press_latency", run_fall_cyc - seg, 32'd5);
        check_eq("run_press_pulses", run_pulses, 32'd1);
        seg = cyc_idx + 1;
        hold(1'b1, 1'b1, 1'b1, 8'h10, 10);
        check_eq("run_release_latency", run_rise_cyc - seg, 32'd5);
        check_eq("run_release_pulses", run_pulses, 32'd1);

        // Bounce shorter than the debounce window is rejected.
        reset_counters();
        hold(1'b1, 1'b0, 1'b1, 8'h10, 3);
        hold(1'b1, 1'b1, 1'b1, 8'h10, 1);
        hold(1'b1, 1'b0, 1'b1, 8'h10, 3);
        hold(1'b1, 1'b1, 1'b1, 8'h10, 8);
        check_eq("glitch_no_fall", run_fall_cyc, 32'hFFFF_FFFF);
        check_eq("glitch_no_pulse", run_pulses, 32'd0);

        // Operand frozen during a run.
        hold(1'b1, 1'b1, 1'b1, 8'h07, 4);
        hold(1'b1, 1'b0, 1'b1, 8'h07, 6);
        hold(1'b1, 1'b0, 1'b1, 8'hC5, 6);
        check_eq("s_frozen", 32'(S), 32'h07);
        hold(1'b1, 1'b1, 1'b1, 8'hC5, 7);
        check_eq("s_after_release", 32'(S), 32'hC5);

        // Reset mid-count, button still held through release.
        reset_counters();
        hold(1'b1, 1'b0, 1'b1, 8'h22, 4);
        cycle(1'b0, 1'b0, 1'b1, 8'h22);
        check_eq("rst_midcount_pulses", run_pulses, 32'd0);
        check_eq("rst_midcount_run", 32'(Run), 32'h1);
        seg = cyc_idx + 1;
        hold(1'b1, 1'b0, 1'b1, 8'h22, 8);
        check_eq("rst_held_latency", run_fall_cyc - seg, 32'd5);
        check_eq("rst_held_pulses", run_pulses, 32'd1);
        hold(1'b1, 1'b1, 1'b1, 8'h22, 8);

        // Simultaneous presses.
        reset_counters();
        seg = cyc_idx + 1;
        hold(1'b1, 1'b0, 1'b0, 8'h5A, 10);
        check_eq("both_run_latency", run_fall_cyc - seg, 32'd5);
        check_eq("both_clr_latency", clr_fall_cyc - seg, 32'd5);
        check_eq("both_pulse_same_cycle", both_pulses, 32'd1);
        check_eq("both_clr_pulses", clr_pulses, 32'd1);
        hold(1'b1, 1'b1, 1'b1, 8'h5A, 10);

        // Randomized bouncing buttons, switch changes and occasional resets.
        rb = 1'b1; cb = 1'b1; sw = 8'h00;
        run_hold = 1; clr_hold = 1;
        for (int c = 0; c < 1500; c++) begin
            run_hold = run_hold - 1;
            if (run_hold == 0) begin rb = ~rb; run_hold = $urandom_range(1, 9); end
            clr_hold = clr_hold - 1;
            if (clr_hold == 0) begin cb = ~cb; clr_hold = $urandom_range(1, 9); end
            if ($urandom_range(0, 3) == 0) sw = W'($urandom);
            rst = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
            cycle(rst, rb, cb, sw);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
